id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline stage of the pipelined RISC-V core. It registers the two register-file read operands together with the decoded instruction fields into the EX stage. It also does the following:
- detects load-use hazards and stalls decode;
- squashes the stage on a taken branch;
- bypasses a same-cycle writeback into the captured operands, so the register file's write-then-read gap never exposes stale data.

It sits directly downstream of the register file's read ports and upstream of the ALU/forwarding logic.

## Interface
Parameters:
- ADDRESS, 5, register index width
- DATA, 32, datapath width
- CTRL_W, 16, width of opaque decoded control bundle

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_A1, id_A2  in  ADDRESS  source register indices (same as register-file A1/A2)
- id_RD1, id_RD2  in  DATA  register-file read data
- id_rd  in  ADDRESS  destination index
- id_imm, id_pc  in  DATA  immediate, instruction PC
- id_ctrl  in  CTRL_W  decoded control, passed through untouched
- id_reg_write, id_mem_read  in  1  instruction writes rd / is a load
- flush  in  1  taken branch/jump resolved in EX
- wb_WE3  in  1  writeback enable (same signal driven to register-file WE3)
- wb_A3  in  ADDRESS  writeback index
- wb_WD3  in  DATA  writeback data
- ex_valid  out  1  EX holds a real instruction
- ex_RD1, ex_RD2, ex_imm, ex_pc  out  DATA  registered operands/fields
- ex_A1, ex_A2, ex_rd  out  ADDRESS  registered indices
- ex_ctrl  out  CTRL_W  registered control
- ex_reg_write, ex_mem_read  out  1  registered; forced 0 when bubble
- stall_id  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt, flush_cnt  out  32  bubble counters

## Operation
- Hazard: `hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_A1 | ex_rd == id_A2)`.
- `stall_id = hz & ~flush`.
- Each rising edge, priority order:
  1. **rst:** all registers 0.
  2. **flush:** load bubble. ex_valid, ex_reg_write and ex_mem_read go to 0; other fields are don't-care but are loaded with 0.
  3. **hz:** load bubble, same as flush; decode holds via stall_id, so the same instruction is re-presented next cycle.
  4. **Otherwise:** capture all id_* fields; ex_valid = id_valid. When id_valid = 0, ex_reg_write and ex_mem_read are forced to 0.
- Operand selection per port n ∈ {1,2} when capturing:
  - if id_An == 0 → 0. This applies even if id_RD n is nonzero, because register x0 is writable in storage.
  - else, with bypass compiled in, if wb_WE3 & wb_A3 == id_An → wb_WD3.
  - else id_RD n.
- Counters:
  - stall_cnt +1 on every edge where a bubble is inserted due to hz and flush = 0.
  - flush_cnt +1 on every edge where flush = 1 (regardless of id_valid).
  - Both saturate at 0xFFFFFFFF and do not wrap.

## Timing
- Latency 1 cycle from id_* to ex_*; no combinational path id_* → ex_*.
- stall_id is a same-cycle combinational output of registered ex_* and the current id_A1/id_A2, id_valid and flush.
- A load-use pair costs exactly one bubble. The cycle after the stall, ex_valid = 0, so hz = 0 and the consumer advances.
- flush and hz asserted together: one bubble, stall_id = 0, flush_cnt +1, stall_cnt unchanged.
- Bypass and hazard together: the hazard wins. Bubble is inserted; the bypass value is not captured.
- Reset mid-operation: asynchronous clear of all outputs regardless of clk; first capture occurs on the first rising edge after rst deasserts.
- Reset values: every output 0, including stall_id (since ex_valid = 0).

## Configuration
- `ID_EX_WB_BYPASS_EN`:
  - **Defined:** the WB→ID bypass described above is present.
  - **Undefined:** operands are taken from id_RD n (x0 still forced to 0). The register file must then provide write-before-read; the bypass mux and the wb_* compare logic are removed. The wb_* ports remain and are ignored.

## Test plan
- **Reset:** rst = 1 mid-stream with ex_valid = 1 → all outputs 0 immediately (before the next edge); stall_cnt = flush_cnt = 0.
- **Pass-through:** id_valid = 1, id_A1 = 3, id_RD1 = 0x11, id_A2 = 4, id_RD2 = 0x22, wb_WE3 = 0 → next edge ex_RD1 = 0x11, ex_RD2 = 0x22, ex_valid = 1.
- **Load-use:** EX holds a load with ex_rd = 5; ID has id_A2 = 5 → stall_id = 1; next edge ex_valid = 0, stall_cnt = 1; following edge the consumer is captured.
- **Bypass:** id_A1 = 7, id_RD1 = 0xAAAA, wb_WE3 = 1, wb_A3 = 7, wb_WD3 = 0x1234 → ex_RD1 = 0x1234. With macro undefined → 0xAAAA.
- **x0:**
  - id_A1 = 0, id_RD1 = 0xDEAD, wb_WE3 = 1, wb_A3 = 0, wb_WD3 = 0xBEEF → ex_RD1 = 0.
  - A load with ex_rd = 0 produces no stall.
- **Flush with hazard:** flush = 1 and hz = 1 in the same cycle → stall_id = 0, ex_valid = 0, flush_cnt +1, stall_cnt unchanged. Preload stall_cnt to 0xFFFFFFFF and trigger hz → counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash and WB->ID bypass.
// Optional WB->ID operand bypass is enabled by defining ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int unsigned ADDRESS = 5,
  parameter int unsigned DATA    = 32,
  parameter int unsigned CTRL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [ADDRESS-1:0] id_A1,
  input  logic [ADDRESS-1:0] id_A2,
  input  logic [DATA-1:0]    id_RD1,
  input  logic [DATA-1:0]    id_RD2,
  input  logic [ADDRESS-1:0] id_rd,
  input  logic [DATA-1:0]    id_imm,
  input  logic [DATA-1:0]    id_pc,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               flush,
  input  logic               wb_WE3,
  input  logic [ADDRESS-1:0] wb_A3,
  input  logic [DATA-1:0]    wb_WD3,
  output logic               ex_valid,
  output logic [DATA-1:0]    ex_RD1,
  output logic [DATA-1:0]    ex_RD2,
  output logic [DATA-1:0]    ex_imm,
  output logic [DATA-1:0]    ex_pc,
  output logic [ADDRESS-1:0] ex_A1,
  output logic [ADDRESS-1:0] ex_A2,
  output logic [ADDRESS-1:0] ex_rd,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               stall_id,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  logic               r_valid;
  logic [DATA-1:0]    r_rd1;
  logic [DATA-1:0]    r_rd2;
  logic [DATA-1:0]    r_imm;
  logic [DATA-1:0]    r_pc;
  logic [ADDRESS-1:0] r_a1;
  logic [ADDRESS-1:0] r_a2;
  logic [ADDRESS-1:0] r_rd;
  logic [CTRL_W-1:0]  r_ctrl;
  logic               r_reg_write;
  logic               r_mem_read;
  logic [31:0]        r_stall_cnt;
  logic [31:0]        r_flush_cnt;

  logic               w_hz;
  logic [DATA-1:0]    w_op1;
  logic [DATA-1:0]    w_op2;

  assign w_hz = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                ((r_rd == id_A1) | (r_rd == id_A2));
  assign stall_id = w_hz & ~flush;

  // x0 reads as zero even though its storage may hold a written value.
  always_comb begin
    w_op1 = id_RD1;
    w_op2 = id_RD2;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_WE3 && (wb_A3 == id_A1)) w_op1 = wb_WD3;
    if (wb_WE3 && (wb_A3 == id_A2)) w_op2 = wb_WD3;
`endif
    if (id_A1 == '0) w_op1 = '0;
    if (id_A2 == '0) w_op2 = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (flush || w_hz) begin
      r_valid     <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_rd1       <= w_op1;
      r_rd2       <= w_op2;
      r_imm       <= id_imm;
      r_pc        <= id_pc;
      r_a1        <= id_A1;
      r_a2        <= id_A2;
      r_rd        <= id_rd;
      r_ctrl      <= id_ctrl;
      r_reg_write <= id_reg_write & id_valid;
      r_mem_read  <= id_mem_read & id_valid;
    end
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
      if (stall_id && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_RD1       = r_rd1;
  assign ex_RD2       = r_rd2;
  assign ex_imm       = r_imm;
  assign ex_pc        = r_pc;
  assign ex_A1        = r_a1;
  assign ex_A2        = r_a2;
  assign ex_rd        = r_rd;
  assign ex_ctrl      = r_ctrl;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule
